// File: rtl/mdio_phy_responder_if.sv
// MDIO pin bundle between the MAC-side MDIO master and the PHY responder.
// master = MAC side (drives mdc/mdio_in), slave = responder (drives mdio_out/mdio_oen).
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_in;
    logic mdio_out;
    logic mdio_oen;

    modport master (output mdc, output mdio_in, input mdio_out, input mdio_oen);
    modport slave  (input mdc, input mdio_in, output mdio_out, output mdio_oen);
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder; drive changes land SYNC_STAGES+1 clk after the MDC edge, no backpressure (paced by MDC).
// Build option MDIO_PREAMBLE_SUPPRESS_EN: accept ST after any run of preamble 1s instead of a full 32.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [15:0] PHY_ID1     = 16'h0141,
    parameter logic [15:0] PHY_ID2     = 16'h0CC2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    mdio_phy_responder_if.slave  mdio,
    output logic [15:0]          ctrl_reg,
    output logic                 wr_strobe,
    output logic [4:0]           wr_regad
);

    localparam logic [15:0] CTRL_DEFAULT = 16'h1140;
    localparam logic [15:0] STATUS_VAL   = 16'h796D;

    typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_ADDR, S_TA, S_DATA} state_t;

    state_t                 r_state, w_state_nxt;
    logic [4:0]             r_bitcnt, w_bitcnt_nxt;
    logic [5:0]             r_pre_cnt, w_pre_nxt;
    logic [SYNC_STAGES-1:0] r_mdc_sync, r_mdio_sync;
    logic                   r_mdc_prev;
    logic                   w_mdc_s, w_bit, w_stb, w_pre_ok, w_respond;
    logic                   r_op_hi, r_is_read, r_ignore;
    logic [8:0]             r_addr;
    logic [15:0]            r_shift;
    logic                   r_mdio_out, r_mdio_oen, r_wr_strobe;
    logic [4:0]             r_wr_regad, w_regad;
    logic [15:0]            r_reg0;
    logic [15:0]            r_regs [0:31];
    logic                   w_drive_ta, w_load, w_shift, w_commit, w_release;
    logic [15:0]            w_rd_data, w_wdata;

    // Synchronisers reset to 1 so a high MDC after reset is not seen as a rising edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_mdc_sync  <= '1;
            r_mdio_sync <= '1;
            r_mdc_prev  <= 1'b1;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdio.mdc};
            r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio.mdio_in};
            r_mdc_prev  <= w_mdc_s;
        end
    end

    assign w_mdc_s   = r_mdc_sync[SYNC_STAGES-1];
    assign w_bit     = r_mdio_sync[SYNC_STAGES-1];
    assign w_stb     = w_mdc_s & ~r_mdc_prev;
    assign w_regad   = r_addr[4:0];
    assign w_respond = r_is_read & ~r_ignore;
    assign w_wdata   = {r_shift[14:0], w_bit};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign w_pre_ok = (r_pre_cnt != 6'd0);
`else
    assign w_pre_ok = (r_pre_cnt == 6'd32);
`endif

    always_comb begin
        case (w_regad)
            5'd0:    w_rd_data = r_reg0;
            5'd1:    w_rd_data = STATUS_VAL;
            5'd2:    w_rd_data = PHY_ID1;
            5'd3:    w_rd_data = PHY_ID2;
            default: w_rd_data = r_regs[w_regad];
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= 5'd0;
            r_pre_cnt <= 6'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_pre_cnt <= w_pre_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_pre_nxt    = r_pre_cnt;
        w_drive_ta   = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_release    = 1'b0;
        if (w_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (w_bit) begin
                        if (r_pre_cnt != 6'd32) w_pre_nxt = r_pre_cnt + 6'd1;
                    end else begin
                        w_pre_nxt = 6'd0;
                        if (w_pre_ok) w_state_nxt = S_ST;
                    end
                end
                S_ST: begin
                    w_bitcnt_nxt = 5'd0;
                    w_state_nxt  = w_bit ? S_OP : S_IDLE;
                end
                S_OP: begin
                    if (r_bitcnt == 5'd0) begin
                        w_bitcnt_nxt = 5'd1;
                    end else begin
                        w_bitcnt_nxt = 5'd0;
                        w_state_nxt  = (r_op_hi != w_bit) ? S_ADDR : S_IDLE;
                    end
                end
                S_ADDR: begin
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                    if (r_bitcnt == 5'd9) begin
                        w_bitcnt_nxt = 5'd0;
                        w_state_nxt  = S_TA;
                    end
                end
                S_TA: begin
                    if (r_bitcnt == 5'd0) begin
                        w_bitcnt_nxt = 5'd1;
                        w_drive_ta   = w_respond;
                    end else begin
                        w_bitcnt_nxt = 5'd0;
                        w_state_nxt  = S_DATA;
                        w_load       = w_respond;
                    end
                end
                S_DATA: begin
                    w_shift      = 1'b1;
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                    if (r_bitcnt == 5'd15) begin
                        w_bitcnt_nxt = 5'd0;
                        w_state_nxt  = S_IDLE;
                        w_pre_nxt    = 6'd0;
                        w_release    = 1'b1;
                        w_commit     = ~r_is_read & ~r_ignore;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_op_hi     <= 1'b0;
            r_is_read   <= 1'b0;
            r_ignore    <= 1'b1;
            r_addr      <= 9'd0;
            r_shift     <= 16'd0;
            r_mdio_out  <= 1'b1;
            r_mdio_oen  <= 1'b1;
            r_wr_strobe <= 1'b0;
            r_wr_regad  <= 5'd0;
            r_reg0      <= CTRL_DEFAULT;
            for (int i = 0; i < 32; i++) r_regs[i] <= 16'd0;
        end else begin
            r_wr_strobe <= w_commit;
            // Soft-reset bit: any value with bit15 set lives one cycle, then defaults return.
            if (r_reg0[15]) r_reg0 <= CTRL_DEFAULT;
            if (w_stb && r_state == S_OP) begin
                if (r_bitcnt == 5'd0) r_op_hi   <= w_bit;
                else                  r_is_read <= r_op_hi;
            end
            if (w_stb && r_state == S_ADDR) begin
                r_addr <= {r_addr[7:0], w_bit};
                if (r_bitcnt == 5'd9) r_ignore <= (r_addr[8:4] != PHY_ADDR);
            end
            if (w_drive_ta) begin
                r_mdio_oen <= 1'b0;
                r_mdio_out <= 1'b0;
            end
            if (w_load) begin
                r_shift    <= w_rd_data;
                r_mdio_out <= w_rd_data[15];
            end
            if (w_shift) begin
                r_shift <= {r_shift[14:0], w_bit};
                if (w_respond) r_mdio_out <= r_shift[14];
            end
            if (w_release) begin
                r_mdio_oen <= 1'b1;
                r_mdio_out <= 1'b1;
            end
            if (w_commit) begin
                r_wr_regad <= w_regad;
                if (w_regad == 5'd0)      r_reg0          <= w_wdata;
                else if (w_regad >= 5'd4) r_regs[w_regad] <= w_wdata;
            end
        end
    end

    assign mdio.mdio_out = r_mdio_out;
    assign mdio.mdio_oen = r_mdio_oen;
    assign ctrl_reg      = r_reg0;
    assign wr_strobe     = r_wr_strobe;
    assign wr_regad      = r_wr_regad;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-banged MDC/MDIO frames, read data checked against a scoreboard queue.
module tb_mdio_phy_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [15:0] ctrl_reg;
    logic        wr_strobe;
    logic [4:0]  wr_regad;

    mdio_phy_responder_if mif ();

    mdio_phy_responder #(
        .PHY_ADDR(5'd0), .PHY_ID1(16'h0141), .PHY_ID2(16'h0CC2), .SYNC_STAGES(2)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .mdio       (mif),
        .ctrl_reg   (ctrl_reg),
        .wr_strobe  (wr_strobe),
        .wr_regad   (wr_regad)
    );

    always #5 clk_clk = ~clk_clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [0:31];
    logic [15:0] exp_v;

    int          oen_lows;
    logic        ta_ok;
    logic        s_oen, s_out;
    logic [15:0] rd_data;

    int          stb_cnt = 0;
    int          stb_wide = 0;
    logic        prev_stb = 1'b0;
    logic [4:0]  stb_regad = '0;
    logic [15:0] stb_ctrl = '0;
    logic [15:0] ctrl_after = '0;

    always @(negedge clk_clk) begin
        if (prev_stb) ctrl_after = ctrl_reg;
        if (wr_strobe) begin
            stb_cnt++;
            if (prev_stb) stb_wide++;
            stb_regad = wr_regad;
            stb_ctrl  = ctrl_reg;
        end
        prev_stb = wr_strobe;
    end

    // One MDC period: MAC changes data on the falling edge, samples the responder just before rising.
    task automatic cyc(input logic b);
        mif.mdc     = 1'b0;
        mif.mdio_in = b;
        repeat (4) @(posedge clk_clk);
        #2;
        s_oen = mif.mdio_oen;
        s_out = mif.mdio_out;
        if (!s_oen) oen_lows++;
        mif.mdc = 1'b1;
        repeat (4) @(posedge clk_clk);
        #2;
    endtask

    task automatic frame(input int pre, input logic rd, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int abort_bit);
        oen_lows = 0;
        ta_ok    = 1'b0;
        rd_data  = 16'hFFFF;
        repeat (pre) cyc(1'b1);
        cyc(1'b0); cyc(1'b1);
        cyc(rd); cyc(~rd);
        for (int i = 4; i >= 0; i--) cyc(phy[i]);
        for (int i = 4; i >= 0; i--) cyc(ra[i]);
        cyc(1'b1);
        cyc(rd ? 1'b1 : 1'b0);
        ta_ok = !s_oen && !s_out;
        for (int i = 15; i >= 0; i--) begin
            cyc(rd ? 1'b1 : wd[i]);
            rd_data[i] = s_oen ? 1'b1 : s_out;
            if (15 - i == abort_bit) return;
        end
        repeat (2) @(posedge clk_clk);
        #2;
    endtask

    task automatic test_reset;
        mif.mdc     = 1'b0;
        mif.mdio_in = 1'b1;
        reset_reset = 1'b1;
        repeat (4) @(posedge clk_clk);
        #2;
        reset_reset = 1'b0;
        model[0] = 16'h1140; model[1] = 16'h796D; model[2] = 16'h0141; model[3] = 16'h0CC2;
        for (int i = 4; i < 32; i++) model[i] = 16'h0000;
        repeat (3) @(posedge clk_clk);
        #2;
        checks++; if (mif.mdio_oen !== 1'b1) begin failures++; $display("FAIL reset_oen got=%b exp=1", mif.mdio_oen); end
        checks++; if (mif.mdio_out !== 1'b1) begin failures++; $display("FAIL reset_out got=%b exp=1", mif.mdio_out); end
        checks++; if (ctrl_reg !== 16'h1140) begin failures++; $display("FAIL reset_ctrl got=%h exp=1140", ctrl_reg); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
        checks++; if (wr_regad !== 5'd0) begin failures++; $display("FAIL reset_wr_regad got=%0d exp=0", wr_regad); end
    endtask

    task automatic test_read_ro;
        for (int r = 1; r <= 3; r++) begin
            exp_q.push_back(model[r]);
            frame(32, 1'b1, 5'd0, 5'(r), 16'h0, -1);
            exp_v = exp_q.pop_front();
            checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL read_reg%0d got=%h exp=%h", r, rd_data, exp_v); end
            checks++; if (oen_lows !== 17) begin failures++; $display("FAIL read_reg%0d_oen_lows got=%0d exp=17", r, oen_lows); end
            checks++; if (ta_ok !== 1'b1) begin failures++; $display("FAIL read_reg%0d_ta got=%b exp=1", r, ta_ok); end
        end
    endtask

    task automatic test_write_reg0;
        int s0;
        s0 = stb_cnt;
        frame(32, 1'b0, 5'd0, 5'd0, 16'h0100, -1);
        model[0] = 16'h0100;
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wr0_pulses got=%0d exp=1", stb_cnt - s0); end
        checks++; if (stb_wide !== 0) begin failures++; $display("FAIL wr0_pulse_width got=%0d exp=0", stb_wide); end
        checks++; if (stb_regad !== 5'd0) begin failures++; $display("FAIL wr0_regad got=%0d exp=0", stb_regad); end
        checks++; if (ctrl_reg !== 16'h0100) begin failures++; $display("FAIL wr0_ctrl got=%h exp=0100", ctrl_reg); end
        checks++; if (oen_lows !== 0) begin failures++; $display("FAIL wr0_oen_lows got=%0d exp=0", oen_lows); end
        exp_q.push_back(model[0]);
        frame(32, 1'b1, 5'd0, 5'd0, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL rd0_after_wr got=%h exp=%h", rd_data, exp_v); end
    endtask

    task automatic test_ctrl_selfclear;
        frame(32, 1'b0, 5'd0, 5'd0, 16'h8000, -1);
        model[0] = 16'h1140;
        checks++; if (stb_ctrl !== 16'h8000) begin failures++; $display("FAIL sc_ctrl_at_commit got=%h exp=8000", stb_ctrl); end
        checks++; if (ctrl_after !== 16'h1140) begin failures++; $display("FAIL sc_ctrl_next got=%h exp=1140", ctrl_after); end
        checks++; if (ctrl_reg !== 16'h1140) begin failures++; $display("FAIL sc_ctrl_later got=%h exp=1140", ctrl_reg); end
    endtask

    task automatic test_write_ro;
        int s0;
        s0 = stb_cnt;
        frame(32, 1'b0, 5'd0, 5'd2, 16'hFFFF, -1);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wr_ro_pulses got=%0d exp=1", stb_cnt - s0); end
        checks++; if (stb_regad !== 5'd2) begin failures++; $display("FAIL wr_ro_regad got=%0d exp=2", stb_regad); end
        exp_q.push_back(model[2]);
        frame(32, 1'b1, 5'd0, 5'd2, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL wr_ro_readback got=%h exp=%h", rd_data, exp_v); end
    endtask

    task automatic test_bad_phyad;
        int s0;
        frame(32, 1'b1, 5'd3, 5'd2, 16'h0, -1);
        checks++; if (oen_lows !== 0) begin failures++; $display("FAIL badad_rd_oen_lows got=%0d exp=0", oen_lows); end
        s0 = stb_cnt;
        frame(32, 1'b0, 5'd3, 5'd4, 16'hBEEF, -1);
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL badad_wr_pulses got=%0d exp=0", stb_cnt - s0); end
        exp_q.push_back(model[4]);
        frame(32, 1'b1, 5'd0, 5'd4, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL badad_next_read got=%h exp=%h", rd_data, exp_v); end
        checks++; if (oen_lows !== 17) begin failures++; $display("FAIL badad_next_oen_lows got=%0d exp=17", oen_lows); end
    endtask

    task automatic test_short_preamble;
        int exp_lows;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        exp_v = model[1];
        exp_lows = 17;
`else
        exp_v = 16'hFFFF;
        exp_lows = 0;
`endif
        exp_q.push_back(exp_v);
        frame(31, 1'b1, 5'd0, 5'd1, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL short_pre_data got=%h exp=%h", rd_data, exp_v); end
        checks++; if (oen_lows !== exp_lows) begin failures++; $display("FAIL short_pre_oen_lows got=%0d exp=%0d", oen_lows, exp_lows); end
        exp_q.push_back(model[1]);
        frame(32, 1'b1, 5'd0, 5'd1, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL short_pre_next got=%h exp=%h", rd_data, exp_v); end
    endtask

    task automatic test_reset_midframe;
        frame(32, 1'b0, 5'd0, 5'd0, 16'h0100, -1);
        frame(32, 1'b0, 5'd0, 5'd9, 16'h5A5A, -1);
        frame(32, 1'b1, 5'd0, 5'd0, 16'h0, 7);
        checks++; if (rd_data[15:8] !== 8'h01) begin failures++; $display("FAIL abort_partial got=%h exp=01", rd_data[15:8]); end
        checks++; if (mif.mdio_oen !== 1'b0) begin failures++; $display("FAIL abort_driving got=%b exp=0", mif.mdio_oen); end
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #2;
        checks++; if (mif.mdio_oen !== 1'b1) begin failures++; $display("FAIL abort_oen got=%b exp=1", mif.mdio_oen); end
        checks++; if (ctrl_reg !== 16'h1140) begin failures++; $display("FAIL abort_ctrl got=%h exp=1140", ctrl_reg); end
        reset_reset = 1'b0;
        for (int i = 4; i < 32; i++) model[i] = 16'h0000;
        model[0] = 16'h1140;
        exp_q.push_back(model[0]);
        frame(32, 1'b1, 5'd0, 5'd0, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL abort_next_read got=%h exp=%h", rd_data, exp_v); end
        checks++; if (oen_lows !== 17) begin failures++; $display("FAIL abort_next_oen_lows got=%0d exp=17", oen_lows); end
        exp_q.push_back(model[9]);
        frame(32, 1'b1, 5'd0, 5'd9, 16'h0, -1);
        exp_v = exp_q.pop_front();
        checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL abort_regs_cleared got=%h exp=%h", rd_data, exp_v); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  ra [0:5];
        logic [15:0] d;
        for (int k = 0; k < 6; k++) begin
            ra[k] = (k == 5) ? 5'd31 : 5'($urandom_range(4, 30));
            d = 16'($urandom);
            frame(32, 1'b0, 5'd0, ra[k], d, -1);
            model[ra[k]] = d;
            checks++; if (stb_regad !== ra[k]) begin failures++; $display("FAIL b2b_wr_regad got=%0d exp=%0d", stb_regad, ra[k]); end
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(model[ra[k]]);
        for (int k = 0; k < 6; k++) begin
            frame(32, 1'b1, 5'd0, ra[k], 16'h0, -1);
            exp_v = exp_q.pop_front();
            checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL b2b_read reg=%0d got=%h exp=%h", ra[k], rd_data, exp_v); end
        end
    endtask

    initial begin
        mif.mdc     = 1'b0;
        mif.mdio_in = 1'b1;
        test_reset();
        test_read_ro();
        test_write_reg0();
        test_ctrl_selfclear();
        test_write_ro();
        test_bad_phyad();
        test_short_preamble();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
